// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline sequencer:
//                FSM state encoding, register-address width, x0 address.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Load-use hazard compare between the load in EX and the
//                source registers of the instruction in ID. A load to x0
//                never creates a hazard.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  mem_read,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  uses_rs2,
    output logic                  load_use
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = (rd_addr == rs1_addr);
    assign rs2_match = uses_rs2 && (rd_addr == rs2_addr);

    // Hazard only when the EX load writes a real register the ID stage reads
    assign load_use = mem_read && (rd_addr != X0_ADDR) && (rs1_match || rs2_match);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Central sequencer for the 5-stage pipeline registers and PC.
//                Produces per-stage write enables, the ID_EX bubble and the
//                IF_ID flush; tracks data-cache stalls with a timeout
//                watchdog and keeps saturating stall / flush counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int STALL_CNT_W = 32,
    parameter int FLUSH_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [REG_ADDR_W-1:0]  ID_rs1addr_i,
    input  logic [REG_ADDR_W-1:0]  ID_rs2addr_i,
    input  logic                   ID_usesRs2_i,
    input  logic                   EX_MemRead_i,
    input  logic [REG_ADDR_W-1:0]  EX_RDaddr_i,
    input  logic                   branch_taken_i,
    input  logic                   dcache_req_i,
    input  logic                   dcache_ack_i,
    output logic                   PC_write_o,
    output logic                   IF_ID_write_o,
    output logic                   IF_ID_flush_o,
    output logic                   ID_EX_write_o,
    output logic                   ID_EX_bubble_o,
    output logic                   EX_MEM_write_o,
    output logic                   MEM_WB_write_o,
    output logic [1:0]             state_o,
    output logic                   halt_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic [FLUSH_CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              wait_expired;
    logic              active;
    logic              mem_stall;
    logic              hazard;
    logic              load_use;
    logic              stall_event;

    hazard_detect u_hazard_detect (
        .mem_read (EX_MemRead_i),
        .rd_addr  (EX_RDaddr_i),
        .rs1_addr (ID_rs1addr_i),
        .rs2_addr (ID_rs2addr_i),
        .uses_rs2 (ID_usesRs2_i),
        .load_use (hazard)
    );

    assign active    = (state == RUN) || (state == MEM_WAIT);
    assign mem_stall = active && dcache_req_i && !dcache_ack_i;

    // A cache stall outranks the load-use hazard, which only matters in RUN
    assign load_use    = (state == RUN) && !mem_stall && hazard;
    assign stall_event = mem_stall || load_use;

    // The wait counter never passes MEM_TIMEOUT, so the increment cannot wrap
    assign wait_inc     = wait_cnt + WAIT_W'(1);
    assign wait_expired = (wait_inc == WAIT_W'(MEM_TIMEOUT));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; start_i is ignored while waiting on the cache
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) state_next = RUN;
            end
            RUN: begin
                if (mem_stall)     state_next = MEM_WAIT;
                else if (!start_i) state_next = IDLE;
            end
            MEM_WAIT: begin
                if (!mem_stall)        state_next = RUN;
                else if (wait_expired) state_next = HALT;
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage enables, bubble and flush decoded from state and hazards
    always_comb begin
        PC_write_o     = 1'b0;
        IF_ID_write_o  = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_write_o  = 1'b0;
        ID_EX_bubble_o = 1'b0;
        EX_MEM_write_o = 1'b0;
        MEM_WB_write_o = 1'b0;
        if (active && !mem_stall) begin
            ID_EX_write_o  = 1'b1;
            EX_MEM_write_o = 1'b1;
            MEM_WB_write_o = 1'b1;
            if (load_use) begin
                // Hold PC/IF_ID, inject a bubble; the branch waits for replay
                ID_EX_bubble_o = 1'b1;
            end else begin
                PC_write_o    = 1'b1;
                IF_ID_write_o = 1'b1;
                IF_ID_flush_o = (state == RUN) && branch_taken_i;
            end
        end
    end

    // Consecutive MEM_WAIT stall cycles; cleared whenever MEM_WAIT is left
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if ((state == MEM_WAIT) && mem_stall && (state_next == MEM_WAIT)) begin
            wait_cnt <= wait_inc;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Saturating count of stalled cycles (cache stall or load-use)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_event && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
        end
    end

    // Saturating count of IF_ID flushes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_cnt_o <= '0;
        end else if (IF_ID_flush_o && (flush_cnt_o != '1)) begin
            flush_cnt_o <= flush_cnt_o + FLUSH_CNT_W'(1);
        end
    end

    assign state_o = state;
    assign halt_o  = (state == HALT);

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Directed, table-driven bench for pipeline_ctrl with
//                hand-written watchdog and reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_ctrl;

    // Enable vector bit order: {PC, IF_ID, flush, ID_EX, bubble, EX_MEM, MEM_WB}
    localparam logic [6:0] EN_NONE = 7'b000_0000;
    localparam logic [6:0] EN_ALL  = 7'b110_1011;
    localparam logic [6:0] EN_LU   = 7'b000_1111;
    localparam logic [6:0] EN_BR   = 7'b111_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  rs1, rs2, rd;
    logic        uses2, memrd, br, req, ack;
    logic        pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_w;
    logic [1:0]  state;
    logic        halt;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .MEM_TIMEOUT (8),
        .STALL_CNT_W (32),
        .FLUSH_CNT_W (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .ID_rs1addr_i   (rs1),
        .ID_rs2addr_i   (rs2),
        .ID_usesRs2_i   (uses2),
        .EX_MemRead_i   (memrd),
        .EX_RDaddr_i    (rd),
        .branch_taken_i (br),
        .dcache_req_i   (req),
        .dcache_ack_i   (ack),
        .PC_write_o     (pc_w),
        .IF_ID_write_o  (ifid_w),
        .IF_ID_flush_o  (ifid_f),
        .ID_EX_write_o  (idex_w),
        .ID_EX_bubble_o (idex_b),
        .EX_MEM_write_o (exmem_w),
        .MEM_WB_write_o (memwb_w),
        .state_o        (state),
        .halt_o         (halt),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    typedef struct {
        logic        start;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        uses2;
        logic        memrd;
        logic [4:0]  rd;
        logic        br;
        logic        req;
        logic        ack;
        logic [6:0]  en;
        logic [1:0]  st;
        logic [31:0] sc;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic [4:0] a1, logic [4:0] a2, logic u2,
                                logic mr, logic [4:0] d, logic b, logic rq, logic ak,
                                logic [6:0] en, logic [1:0] st, logic [31:0] sc,
                                logic [15:0] fc);
        vec_t v;
        v.start = s;  v.rs1 = a1; v.rs2 = a2; v.uses2 = u2; v.memrd = mr;
        v.rd = d;     v.br = b;   v.req = rq; v.ack = ak;
        v.en = en;    v.st = st;  v.sc = sc;  v.fc = fc;
        return v;
    endfunction

    // Vector with hazard-free register addresses
    function automatic vec_t dv(logic s, logic rq, logic ak, logic [6:0] en,
                                logic [1:0] st, logic [31:0] sc, logic [15:0] fc);
        return mk(s, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, rq, ak, en, st, sc, fc);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [6:0] en, input logic [1:0] st,
                                 input logic [31:0] sc, input logic [15:0] fc);
        n_vec++;
        chk("enables", idx, 32'({pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_w}),
            32'(en));
        chk("state",     idx, 32'(state),     32'(st));
        chk("halt",      idx, 32'(halt),      32'(st == 2'd3));
        chk("stall_cnt", idx, stall_cnt,      sc);
        chk("flush_cnt", idx, 32'(flush_cnt), 32'(fc));
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance one cycle
    task automatic step(input vec_t v, input int idx);
        start = v.start; rs1 = v.rs1; rs2 = v.rs2; uses2 = v.uses2; memrd = v.memrd;
        rd = v.rd; br = v.br; req = v.req; ack = v.ack;
        @(negedge clk);
        check_outputs(idx, v.en, v.st, v.sc, v.fc);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse in the middle of a cycle, checked before release
    task automatic reset_pulse(input int idx);
        start = 1'b0; req = 1'b0; ack = 1'b0;
        rst = 1'b1;
        #2;
        check_outputs(idx, EN_NONE, 2'd0, 32'd0, 16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rs1 = 5'd1; rs2 = 5'd2; uses2 = 1'b1;
        memrd = 1'b0; rd = 5'd3; br = 1'b0; req = 1'b0; ack = 1'b0;

        //            start rs1   rs2   u2    mrd   rd    br    req   ack   en       st    sc  fc
        tbl.push_back(dv(1'b0, 1'b0, 1'b0, EN_NONE, 2'd0, 0, 0));                          // 0
        tbl.push_back(dv(1'b0, 1'b0, 1'b0, EN_NONE, 2'd0, 0, 0));                          // 1
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, EN_NONE, 2'd0, 0, 0));                          // 2
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, EN_ALL,  2'd1, 0, 0));                          // 3
        tbl.push_back(mk(1, 5'd5, 5'd2, 1, 1, 5'd5, 0, 0, 0, EN_LU,   2'd1, 0, 0));        // 4 rs1 load-use
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, EN_ALL,  2'd1, 1, 0));                          // 5
        tbl.push_back(mk(1, 5'd0, 5'd2, 1, 1, 5'd0, 0, 0, 0, EN_ALL,  2'd1, 1, 0));        // 6 load to x0
        tbl.push_back(mk(1, 5'd1, 5'd6, 0, 1, 5'd6, 0, 0, 0, EN_ALL,  2'd1, 1, 0));        // 7 rs2 unused
        tbl.push_back(mk(1, 5'd1, 5'd6, 1, 1, 5'd6, 0, 0, 0, EN_LU,   2'd1, 1, 0));        // 8 rs2 load-use
        tbl.push_back(mk(1, 5'd1, 5'd2, 1, 0, 5'd3, 1, 0, 0, EN_BR,   2'd1, 2, 0));        // 9 branch
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, EN_ALL,  2'd1, 2, 1));                          // 10
        tbl.push_back(mk(1, 5'd5, 5'd2, 1, 1, 5'd5, 1, 0, 0, EN_LU,   2'd1, 2, 1));        // 11 branch+load-use
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, EN_ALL,  2'd1, 3, 1));                          // 12
        tbl.push_back(mk(1, 5'd5, 5'd2, 1, 1, 5'd5, 1, 1, 0, EN_NONE, 2'd1, 3, 1));        // 13 stall beats hazard
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, EN_NONE, 2'd2, 4, 1));                          // 14
        tbl.push_back(dv(1'b0, 1'b1, 1'b0, EN_NONE, 2'd2, 5, 1));                          // 15 start ignored
        tbl.push_back(dv(1'b1, 1'b1, 1'b0, EN_NONE, 2'd2, 6, 1));                          // 16
        tbl.push_back(dv(1'b1, 1'b1, 1'b1, EN_ALL,  2'd2, 7, 1));                          // 17 ack
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, EN_ALL,  2'd1, 7, 1));                          // 18
        tbl.push_back(dv(1'b0, 1'b0, 1'b0, EN_ALL,  2'd1, 7, 1));                          // 19 stop, RUN rules
        tbl.push_back(dv(1'b0, 1'b0, 1'b0, EN_NONE, 2'd0, 7, 1));                          // 20
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, EN_NONE, 2'd0, 7, 1));                          // 21
        tbl.push_back(dv(1'b1, 1'b0, 1'b0, EN_ALL,  2'd1, 7, 1));                          // 22

        // Reset state while rst is held
        @(negedge clk);
        check_outputs(-1, EN_NONE, 2'd0, 32'd0, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i], i);

        // Watchdog: one RUN stall cycle, then 8 MEM_WAIT cycles, then HALT
        step(dv(1'b1, 1'b1, 1'b0, EN_NONE, 2'd1, 7, 1), 100);
        for (int i = 0; i < 8; i++)
            step(dv(i[0], 1'b1, 1'b0, EN_NONE, 2'd2, 32'(8 + i), 1), 101 + i);
        for (int i = 0; i < 4; i++)
            step(dv(~i[0], i[0], i[1], EN_NONE, 2'd3, 16, 1), 110 + i);
        reset_pulse(120);

        // Reset while waiting on the cache
        step(dv(1'b1, 1'b0, 1'b0, EN_NONE, 2'd0, 0, 0), 130);
        step(dv(1'b1, 1'b1, 1'b0, EN_NONE, 2'd1, 0, 0), 131);
        step(dv(1'b1, 1'b1, 1'b0, EN_NONE, 2'd2, 1, 0), 132);
        step(dv(1'b1, 1'b1, 1'b0, EN_NONE, 2'd2, 2, 0), 133);
        reset_pulse(134);
        step(dv(1'b0, 1'b0, 1'b0, EN_NONE, 2'd0, 0, 0), 135);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire
